// File: rtl/score_keeper_if.sv
// Event and display bus between the collision logic, the score keeper and the display stage.
// master drives gameplay pulses and observes scores; slave is the score keeper itself.
interface score_keeper_if;
    logic        start;
    logic        brick_hit;
    logic [2:0]  brick_row;
    logic        paddle_hit;
    logic        ball_lost;
    logic [13:0] current_score;
    logic [13:0] high_score;
    logic [1:0]  lives;
    logic [2:0]  combo;
    logic        playing;
    logic        game_over;

    modport master (
        output start, brick_hit, brick_row, paddle_hit, ball_lost,
        input  current_score, high_score, lives, combo, playing, game_over
    );

    modport slave (
        input  start, brick_hit, brick_row, paddle_hit, ball_lost,
        output current_score, high_score, lives, combo, playing, game_over
    );
endinterface

// File: rtl/score_keeper.sv
// Breakout scoring: running score, session high score, lives and hit-combo multiplier.
// All outputs come straight from registers; every event is applied on the edge that samples it.
module score_keeper #(
    parameter int MAX_SCORE   = 9999,
    parameter int START_LIVES = 3,
    parameter int COMBO_MAX   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    score_keeper_if.slave bus
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_PLAY = 2'd1;
    localparam logic [1:0]  ST_OVER = 2'd2;

    localparam logic [13:0] C_MAX_SCORE = 14'(MAX_SCORE);
    localparam logic [1:0]  C_LIVES     = 2'(START_LIVES);
    localparam logic [2:0]  C_COMBO_MAX = 3'(COMBO_MAX);

    logic [1:0]  r_state;
    logic [13:0] r_score;
    logic [13:0] r_high;
    logic [1:0]  r_lives;
    logic [2:0]  r_combo;
    logic        r_playing;
    logic        r_game_over;

    logic [2:0]  w_points;
    logic [5:0]  w_award;
    logic [14:0] w_sum;
    logic [13:0] w_brick_score;
    logic [13:0] w_new_score;
    logic [13:0] w_new_high;
    logic [2:0]  w_new_combo;
    logic        w_start_game;

    function automatic logic [2:0] row_points(input logic [2:0] row);
        logic [2:0] pts;
        case (row[2:1])
            2'd0:    pts = 3'd7;
            2'd1:    pts = 3'd5;
            2'd2:    pts = 3'd3;
            default: pts = 3'd1;
        endcase
        return pts;
    endfunction

    // Next-value arithmetic for score, high score and combo while playing.
    always_comb begin
        w_points = row_points(bus.brick_row);
        w_award  = {3'b000, w_points} * {3'b000, r_combo};
        w_sum    = {1'b0, r_score} + {9'd0, w_award};
        if (w_sum > {1'b0, C_MAX_SCORE}) begin
            w_brick_score = C_MAX_SCORE;
        end else begin
            w_brick_score = w_sum[13:0];
        end
        if (bus.brick_hit) begin
            w_new_score = w_brick_score;
        end else begin
            w_new_score = r_score;
        end
        // High score compares against the score including a same-cycle brick.
        if (w_new_score > r_high) begin
            w_new_high = w_new_score;
        end else begin
            w_new_high = r_high;
        end
        if (bus.paddle_hit || bus.ball_lost) begin
            w_new_combo = 3'd1;
        end else if (bus.brick_hit) begin
            if (r_combo >= C_COMBO_MAX) begin
                w_new_combo = C_COMBO_MAX;
            end else begin
                w_new_combo = r_combo + 3'd1;
            end
        end else begin
            w_new_combo = r_combo;
        end
        w_start_game = bus.start && (r_state != ST_PLAY);
    end

    // Game FSM and all score/lives/combo registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_score     <= 14'd0;
            r_high      <= 14'd0;
            r_lives     <= C_LIVES;
            r_combo     <= 3'd1;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (w_start_game) begin
                        r_state     <= ST_PLAY;
                        r_score     <= 14'd0;
                        r_lives     <= C_LIVES;
                        r_combo     <= 3'd1;
                        r_playing   <= 1'b1;
                        r_game_over <= 1'b0;
                    end else begin
                        r_state     <= r_state;
                    end
                end
                ST_PLAY: begin
                    r_score <= w_new_score;
                    r_combo <= w_new_combo;
                    if (bus.ball_lost) begin
                        r_lives <= r_lives - 2'd1;
                        if (r_lives == 2'd1) begin
                            r_state     <= ST_OVER;
                            r_high      <= w_new_high;
                            r_playing   <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state     <= ST_PLAY;
                        end
                    end else begin
                        r_lives <= r_lives;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign bus.current_score = r_score;
    assign bus.high_score    = r_high;
    assign bus.lives         = r_lives;
    assign bus.combo         = r_combo;
    assign bus.playing       = r_playing;
    assign bus.game_over     = r_game_over;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random event traffic,
// all compared against an integer game model held in the bench.
module tb_score_keeper;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    // Reference model: plain integers, mode 0 = idle, 1 = playing, 2 = over.
    int m_mode;
    int m_score;
    int m_high;
    int m_lives;
    int m_combo;

    score_keeper_if sk_if ();

    score_keeper #(
        .MAX_SCORE   (9999),
        .START_LIVES (3),
        .COMBO_MAX   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sk_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_score = 0;
        m_high  = 0;
        m_lives = 3;
        m_combo = 1;
    endtask

    task automatic model_event(input bit s, input bit h, input int row, input bit p, input bit l);
        int pts;
        if (m_mode == 1) begin
            if (h) begin
                pts     = 7 - 2 * (row / 2);
                m_score = m_score + pts * m_combo;
                if (m_score > 9999) m_score = 9999;
                m_combo = (m_combo + 1 > 4) ? 4 : m_combo + 1;
            end
            if (p || l) m_combo = 1;
            if (l) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) begin
                    m_mode = 2;
                    if (m_score > m_high) m_high = m_score;
                end
            end
        end else if (s) begin
            m_mode  = 1;
            m_score = 0;
            m_lives = 3;
            m_combo = 1;
        end
    endtask

    task automatic compare_all();
        chk("current_score", int'(sk_if.current_score), m_score);
        chk("high_score",    int'(sk_if.high_score),    m_high);
        chk("lives",         int'(sk_if.lives),         m_lives);
        chk("combo",         int'(sk_if.combo),         m_combo);
        chk("playing",       int'(sk_if.playing),       (m_mode == 1) ? 1 : 0);
        chk("game_over",     int'(sk_if.game_over),     (m_mode == 2) ? 1 : 0);
        chk("not_both",      int'(sk_if.playing & sk_if.game_over), 0);
    endtask

    task automatic step(input bit s, input bit h, input int row, input bit p, input bit l);
        @(negedge clk);
        sk_if.start      = s;
        sk_if.brick_hit  = h;
        sk_if.brick_row  = 3'(row);
        sk_if.paddle_hit = p;
        sk_if.ball_lost  = l;
        @(posedge clk);
        #1;
        model_event(s, h, row, p, l);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        sk_if.start      = 1'b0;
        sk_if.brick_hit  = 1'b0;
        sk_if.brick_row  = 3'd0;
        sk_if.paddle_hit = 1'b0;
        sk_if.ball_lost  = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        model_reset();

        do_reset();
        chk("reset_score", int'(sk_if.current_score), 0);
        chk("reset_lives", int'(sk_if.lives), 3);
        chk("reset_combo", int'(sk_if.combo), 1);

        // Opening rows 7, 7, 0.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("start_playing", int'(sk_if.playing), 1);
        step(1'b0, 1'b1, 7, 1'b0, 1'b0);
        chk("hit1_score", int'(sk_if.current_score), 1);
        chk("hit1_combo", int'(sk_if.combo), 2);
        step(1'b0, 1'b1, 7, 1'b0, 1'b0);
        chk("hit2_score", int'(sk_if.current_score), 3);
        chk("hit2_combo", int'(sk_if.combo), 3);
        step(1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("hit3_score", int'(sk_if.current_score), 24);
        chk("hit3_combo", int'(sk_if.combo), 4);

        // Brick plus paddle at combo 4: scored at old combo, then combo drops.
        step(1'b0, 1'b1, 2, 1'b1, 1'b0);
        chk("paddle_score", int'(sk_if.current_score), 44);
        chk("paddle_combo", int'(sk_if.combo), 1);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("start_in_play_ignored", int'(sk_if.current_score), 44);

        // Three lost balls end the game.
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("lives_2", int'(sk_if.lives), 2);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("lives_1", int'(sk_if.lives), 1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("lives_0", int'(sk_if.lives), 0);
        chk("over_flag", int'(sk_if.game_over), 1);
        chk("over_playing", int'(sk_if.playing), 0);
        chk("over_high", int'(sk_if.high_score), 44);
        step(1'b0, 1'b1, 0, 1'b1, 1'b1);
        chk("over_hit_ignored", int'(sk_if.current_score), 44);

        // New game keeps high score; drive it into saturation.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("restart_score", int'(sk_if.current_score), 0);
        chk("restart_high", int'(sk_if.high_score), 44);
        for (int i = 0; i < 365; i++) step(1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("saturate", int'(sk_if.current_score), 9999);
        step(1'b0, 1'b1, 1, 1'b0, 1'b0);
        chk("saturate_hold", int'(sk_if.current_score), 9999);
        chk("saturate_high_unchanged", int'(sk_if.high_score), 44);

        // Reset, then build lives=1, score=100, combo=2 and lose the last ball with a row-0 hit.
        do_reset();
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 6, 1'b1, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("setup_score", int'(sk_if.current_score), 100);
        chk("setup_combo", int'(sk_if.combo), 2);
        chk("setup_lives", int'(sk_if.lives), 1);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1);
        chk("final_score", int'(sk_if.current_score), 114);
        chk("final_high", int'(sk_if.high_score), 114);
        chk("final_over", int'(sk_if.game_over), 1);

        // Lower second game keeps the earlier high score.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0, 1'b0, 1'b1);
        chk("retain_high", int'(sk_if.high_score), 114);

        // Mid-game reset at score 50 clears everything, high score included.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 7, 1'b1, 1'b0);
        chk("pre_reset_score", int'(sk_if.current_score), 50);
        do_reset();
        chk("mid_reset_high", int'(sk_if.high_score), 0);
        chk("mid_reset_playing", int'(sk_if.playing), 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                step($urandom_range(0, 19) == 0,
                     $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 7)),
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) == 0);
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-state scoring block for Breakout. Consumes single-cycle gameplay events from the ball/brick collision logic, maintains the running score, the session high score, lives and a hit-combo multiplier, and drives the 14-bit `current_score` / `high_score` buses into the seven-segment display stage. Both score buses are plain binary, capped at 9999 so they always fit four decimal digits.

## Interface
Parameters:
- `MAX_SCORE`, 9999: saturation ceiling for both scores; must be ≤ 16383.
- `START_LIVES`, 3: lives loaded on reset and on every new game; range 1..3.
- `COMBO_MAX`, 4: multiplier ceiling; range 1..7.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle pulse that begins a new game.
- `brick_hit` in 1: single-cycle pulse, one brick destroyed.
- `brick_row` in 3: row of the destroyed brick, 0 = top; sampled only with `brick_hit`.
- `paddle_hit` in 1: single-cycle pulse, ball touched the paddle.
- `ball_lost` in 1: single-cycle pulse, ball left the bottom of the field.
- `current_score` out 14: registered score of the current or most recent game.
- `high_score` out 14: registered best score since reset.
- `lives` out 2: registered lives remaining.
- `combo` out 3: registered current multiplier, 1..`COMBO_MAX`.
- `playing` out 1: high in PLAY.
- `game_over` out 1: high in OVER.

## Operation
- FSM states:
  - IDLE, the reset state. `start` moves it to PLAY.
  - PLAY. A `ball_lost` while `lives == 1` moves it to OVER.
  - OVER. `start` moves it to PLAY.
- Entering PLAY, on the `start` edge: `current_score` ← 0, `lives` ← `START_LIVES`, `combo` ← 1. `high_score` is kept.
- `start` while in PLAY is ignored.
- `brick_hit`, `paddle_hit` and `ball_lost` are ignored outside PLAY.
- Row points:
  - rows 0–1: 7
  - rows 2–3: 5
  - rows 4–5: 3
  - rows 6–7: 1
- Each brick award is row points × `combo`, using `combo` before this cycle's update. The maximum award is 7 × `COMBO_MAX`.
- Score update: sum = `current_score` + award, computed at 15 bits. If sum > `MAX_SCORE`, `current_score` ← `MAX_SCORE`. Never wraps.
- Combo rules:
  - After a brick award, `combo` ← min(`combo` + 1, `COMBO_MAX`).
  - `paddle_hit` or `ball_lost` sets `combo` ← 1. This takes priority over the brick increment in the same cycle.
- `ball_lost` decrements `lives`.
  - If `lives` was 1: `lives` ← 0, state ← OVER.
  - On that same edge, `high_score` ← max(`high_score`, updated `current_score`), where the updated score includes any same-cycle brick award.
- In OVER, `current_score` holds the final score for display until the next `start`.
- Simultaneous events in PLAY, same cycle:
  - `brick_hit` + `ball_lost`: the brick is scored at the old combo, a life is lost, combo ← 1.
  - `brick_hit` + `paddle_hit`: the brick is scored at the old combo, combo ← 1.
- `high_score` changes only on entry to OVER or on reset.

## Timing
- Reset values (`rst_n` low at an edge):
  - `current_score` = 0
  - `high_score` = 0
  - `lives` = `START_LIVES`
  - `combo` = 1
  - `playing` = 0
  - `game_over` = 0
  - state = IDLE
- Reset mid-game aborts it and also clears `high_score`.
- Latency: every output reflects an input pulse on the edge that samples it, so it is visible 1 cycle after the pulse.
- No combinational path from any input to any output.
- Back-to-back pulses on consecutive cycles are each processed fully; no events are lost.
- `playing` and `game_over` are one-hot or both low; never both high.
- Outputs are stable between events, so the display stage may sample at any divided rate.

## Test plan
- Reset, then `start`, then `brick_hit` for rows 7, 7, 0:
  - `current_score` 1 → 3 → 24
  - `combo` 2 → 3 → 4
- Combo reset: at `combo` = 4, assert `brick_hit` (row 2) together with `paddle_hit`:
  - `current_score` += 20
  - `combo` = 1 next cycle
- Saturation: with `current_score` = 9990 and `combo` = 4, a row-0 hit must give `current_score` = 9999. Further hits hold 9999.
- Game over with `START_LIVES` = 3:
  - Three `ball_lost` pulses give `lives` 2, 1, 0.
  - `game_over` = 1 and `playing` = 0 after the third.
  - `high_score` = final score.
  - Later `brick_hit` pulses leave the score unchanged.
- High-score retention:
  - Game 1 ends at 120, game 2 ends at 45: `high_score` stays 120.
  - `start` clears `current_score` to 0 but not `high_score`.
- Final-life simultaneity: `lives` = 1, `current_score` = 100 and `combo` = 2; assert a row-0 `brick_hit` together with `ball_lost`:
  - `current_score` = 114
  - `high_score` = 114
  - `game_over` = 1, on the same edge.
- Reset mid-game with score 50: all outputs return to their reset values next cycle, including `high_score` = 0.
